// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that pops bytes from a registered-read FIFO and
// serializes them LSB first on a glitch-free registered tx line.
module uart_fifo_tx #(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  input  logic        tx_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] sent_count
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shift, shift_n;
  logic           tx_n, rd_en_n;
  logic [15:0]    sent_count_n;

  // FIFO read handshake: fifo_rd_en is high for the single FETCH cycle; the
  // FIFO presents the popped byte on fifo_data from that edge on, so LOAD
  // captures it one cycle later. fifo_empty is only consulted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      sent_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_en_n;
      sent_count <= sent_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    tx_n         = tx;
    rd_en_n      = 1'b0;
    sent_count_n = sent_count;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty && tx_en) begin
          state_n = FETCH;
          rd_en_n = 1'b1;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n = fifo_data;
        cnt_n   = '0;
        tx_n    = 1'b0;
        state_n = START;
      end
      START: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
          state_n   = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          // tx is registered, so the next bit is loaded one edge early.
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n = shift[1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n        = '0;
          sent_count_n = sent_count + 16'd1;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx at CLK_DIV=4: FIFO model, frame-decoding
// monitor checked against a queue of hand-computed 10-bit frames.
module tb_uart_fifo_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        tx_en;
  logic        tx;
  logic        busy;
  logic [15:0] sent_count;

  logic [7:0]  fmem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  int          rd_cycles = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [9:0]  exp_q[$];
  int          start_q[$];

  uart_fifo_tx #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx_en      (tx_en),
    .tx         (tx),
    .busy       (busy),
    .sent_count (sent_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model with registered read data
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_data <= fmem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end
  always @(posedge clk) if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
  always @(negedge clk) if (fifo_rd_en) rd_cycles <= rd_cycles + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [9:0] frame, input bit expect_frame);
    fmem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
    if (expect_frame) exp_q.push_back(frame);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k;
    k = 0;
    while (start_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", 32'(start_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: decode each frame sampled on negedges and score it
  initial begin
    logic [9:0] fr, req;
    bit aborted, unstable;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        fr = '0;
        fr[0] = tx;
        aborted = 0;
        unstable = 0;
        for (int i = 1; i < 40 && !aborted; i++) begin
          @(negedge clk);
          if (rst) aborted = 1;
          else if (i % 4 == 0) fr[i / 4] = tx;
          else if (tx !== fr[i / 4]) unstable = 1;
        end
        if (aborted) begin
          if (exp_q.size() > 0) req = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", {22'd0, fr}, 32'h3ff);
        end else begin
          req = exp_q.pop_front();
          check("frame", {22'd0, fr}, {22'd0, req});
          check("bit_stable", 32'(unstable), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, s0, base, p0, r0, bad;
    rst = 1'b1;
    tx_en = 1'b1;

    // reset held with a non-empty FIFO
    push_byte(8'hA5, 10'b1_1010_0101_0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sent", 32'(sent_count), 32'd0);
    end
    check("rst_no_pop", 32'(pop_cnt), 32'd0);

    // single byte 0xA5
    p0 = pop_cnt; r0 = rd_cycles; base = start_q.size();
    rst = 1'b0;
    t0 = cyc;
    wait_starts(base + 1, 50);
    s0 = start_q[base];
    check("a5_latency", 32'(s0 - t0), 32'd3);
    wait_until(s0 + 40);
    check("a5_sent", 32'(sent_count), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);
    check("a5_pops", 32'(pop_cnt - p0), 32'd1);
    check("a5_rd_width", 32'(rd_cycles - r0), 32'd1);

    // back-to-back 0x00, 0xFF, 0x55
    do_reset();
    @(negedge clk);
    p0 = pop_cnt; base = start_q.size(); t0 = cyc;
    push_byte(8'h00, 10'b1_0000_0000_0, 1'b1);
    push_byte(8'hFF, 10'b1_1111_1111_0, 1'b1);
    push_byte(8'h55, 10'b1_0101_0101_0, 1'b1);
    wait_starts(base + 3, 300);
    check("b2b_latency", 32'(start_q[base] - t0), 32'd3);
    check("b2b_gap1", 32'(start_q[base + 1] - start_q[base]), 32'd43);
    check("b2b_gap2", 32'(start_q[base + 2] - start_q[base + 1]), 32'd43);
    wait_until(start_q[base + 2] + 40);
    check("b2b_sent", 32'(sent_count), 32'd3);
    check("b2b_pops", 32'(pop_cnt - p0), 32'd3);
    check("b2b_empty", 32'(fifo_empty), 32'd1);
    check("b2b_busy", 32'(busy), 32'd0);
    check("b2b_tx", 32'(tx), 32'd1);

    // flow control hold, then tx_en dropped mid-frame
    @(negedge clk);
    tx_en = 1'b0;
    p0 = pop_cnt; base = start_q.size();
    push_byte(8'h3C, 10'b1_0011_1100_0, 1'b1);
    push_byte(8'h81, 10'b1_1000_0001_0, 1'b0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
    end
    check("flow_hold", 32'(bad), 32'd0);
    check("flow_no_pop", 32'(pop_cnt - p0), 32'd0);
    tx_en = 1'b1;
    t0 = cyc;
    wait_starts(base + 1, 50);
    s0 = start_q[base];
    check("flow_latency", 32'(s0 - t0), 32'd3);
    wait_until(s0 + 12);
    tx_en = 1'b0;
    wait_until(s0 + 90);
    check("drop_no_next", 32'(start_q.size() - base), 32'd1);
    check("drop_sent", 32'(sent_count), 32'd4);
    check("drop_pops", 32'(pop_cnt - p0), 32'd1);
    check("drop_fifo_left", 32'(fifo_empty), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);

    // reset during bit 4 of 0x81
    exp_q.push_back(10'b1_1000_0001_0);
    p0 = pop_cnt; base = start_q.size();
    tx_en = 1'b1;
    wait_starts(base + 1, 50);
    s0 = start_q[base];
    wait_until(s0 + 4 + 16 + 1);
    check("mid_bit4", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sent", 32'(sent_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("mid_stay_idle", 32'(bad), 32'd0);
    check("mid_pops", 32'(pop_cnt - p0), 32'd1);
    check("mid_no_restart", 32'(start_q.size() - base), 32'd1);

    // sent_count wrap
    @(negedge clk);
    force dut.sent_count = 16'hFFFF;
    @(negedge clk);
    release dut.sent_count;
    check("wrap_preload", 32'(sent_count), 32'h0000FFFF);
    base = start_q.size();
    push_byte(8'hC3, 10'b1_1100_0011_0, 1'b1);
    wait_starts(base + 1, 50);
    s0 = start_q[base];
    wait_until(s0 + 40);
    check("wrap_sent", 32'(sent_count), 32'd0);
    check("wrap_busy", 32'(busy), 32'd0);

    bad = 0;
    while (exp_q.size() > 0 && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
